// File: rtl/arf_sched_core.sv
// arf_sched_core: time-multiplexed two-output recursive filter stage.
// One sample (eight W-bit lanes) is accepted in IDLE and then walks through
// MUL1 -> ADD -> MUL2 -> OUT, one cycle each. The results are held in OUT
// until they are accepted. On acceptance they are fed back as fb0/fb1.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   x_in[8*W]                   packed samples x0..x7, with x0 at the LSBs
//   in_valid / in_ready         input handshake (in_ready is high only in IDLE)
//   approx_en, sat_en           per-sample mode bits, captured at the handshake
//   coef_we/coef_addr/wdata     coefficient file c0..c11, writable only in IDLE
//   clear_state                 zeroes fb0/fb1 (only acted on in IDLE)
//   y0, y1, out_valid/out_ready result handshake
//   busy                        high whenever the FSM is not in IDLE

// Signed QFRAC multiply: shift, saturate to W bits, then optionally
// clear the low APPROX_BITS bits.
module arf_sched_mul #(
  parameter int W = 16,
  parameter int FRAC = 8,
  parameter int APPROX_BITS = 4
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                approx,
  output logic signed [W-1:0] p
);
  localparam logic signed [2*W-1:0] MAXV = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] MINV = {{(W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0] AMASK = W'((1 << APPROX_BITS) - 1);

  logic signed [2*W-1:0] prod, sh;
  logic signed [W-1:0]   satv;

  assign prod = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
  assign sh   = prod >>> FRAC;
  assign satv = (sh > MAXV) ? MAXV[W-1:0] : (sh < MINV) ? MINV[W-1:0] : sh[W-1:0];
  assign p    = approx ? (satv & ~AMASK) : satv;
endmodule

module arf_sched_core #(
  parameter int W = 16,
  parameter int FRAC = 8,
  parameter int APPROX_BITS = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [8*W-1:0] x_in,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           approx_en,
  input  logic           sat_en,
  input  logic           coef_we,
  input  logic [3:0]     coef_addr,
  input  logic [W-1:0]   coef_wdata,
  input  logic           clear_state,
  output logic [W-1:0]   y0,
  output logic [W-1:0]   y1,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy
);
  typedef enum logic [2:0] {IDLE, MUL1, ADD, MUL2, OUT} state_t;

  localparam logic signed [W+2:0] MAX3 = {4'b0000, {(W-1){1'b1}}};
  localparam logic signed [W+2:0] MIN3 = {4'b1111, {(W-1){1'b0}}};

  state_t                state;
  logic [7:0][W-1:0]     x_r;
  logic [11:0][W-1:0]    coef;
  logic [7:0][W-1:0]     p_n, p_r;
  logic [3:0][W-1:0]     q_n;
  logic signed [W-1:0]   b0, b1, fb0, fb1;
  logic                  approx_r, sat_r;
  logic signed [W+2:0]   s0, s1, t0, t1;

  function automatic logic signed [W+2:0] ext(input logic [W-1:0] v);
    return {{3{v[W-1]}}, v};
  endfunction

  // Fold a wide sum back into W bits, saturating or wrapping.
  function automatic logic [W-1:0] fit(input logic signed [W+2:0] v, input logic s);
    if (s && v > MAX3) return MAX3[W-1:0];
    if (s && v < MIN3) return MIN3[W-1:0];
    return v[W-1:0];
  endfunction

  // Eight MUL1 lanes: p_i = x_i * c_i.
  for (genvar i = 0; i < 8; i++) begin : g_mul1
    arf_sched_mul #(.W(W), .FRAC(FRAC), .APPROX_BITS(APPROX_BITS)) u_mul (
      .a(x_r[i]), .b(coef[i]), .approx(approx_r), .p(p_n[i]));
  end

  // Four MUL2 lanes: lanes 0 and 2 take b0, lanes 1 and 3 take b1, with coefficients c8..c11.
  for (genvar j = 0; j < 4; j++) begin : g_mul2
    arf_sched_mul #(.W(W), .FRAC(FRAC), .APPROX_BITS(APPROX_BITS)) u_mul (
      .a((j % 2 == 0) ? b0 : b1), .b(coef[8+j]), .approx(approx_r), .p(q_n[j]));
  end

  assign s0 = ext(p_r[0]) + ext(p_r[1]) + ext(p_r[2]) + ext(p_r[3]) + ext(fb0);
  assign s1 = ext(p_r[4]) + ext(p_r[5]) + ext(p_r[6]) + ext(p_r[7]) + ext(fb1);
  assign t0 = ext(q_n[0]) + ext(q_n[1]);
  assign t1 = ext(q_n[2]) + ext(q_n[3]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      y0        <= '0;
      y1        <= '0;
      fb0       <= '0;
      fb1       <= '0;
      coef      <= '0;
      x_r       <= '0;
      p_r       <= '0;
      b0        <= '0;
      b1        <= '0;
      approx_r  <= 1'b0;
      sat_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A coefficient write or a clear in the handshake cycle is seen by that same sample.
          // This works because coefficients are first read in MUL1 and fb is first read in ADD.
          if (coef_we && coef_addr < 4'd12) coef[coef_addr] <= coef_wdata;
          if (clear_state) begin
            fb0 <= '0;
            fb1 <= '0;
          end
          if (in_valid) begin
            x_r      <= x_in;
            approx_r <= approx_en;
            sat_r    <= sat_en;
            state    <= MUL1;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        MUL1: begin
          p_r   <= p_n;
          state <= ADD;
        end
        ADD: begin
          b0    <= fit(s0, sat_r);
          b1    <= fit(s1, sat_r);
          state <= MUL2;
        end
        MUL2: begin
          y0        <= fit(t0, sat_r);
          y1        <= fit(t1, sat_r);
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            fb0       <= y0;
            fb1       <= y1;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/arf_sched_core.md
ARF_SCHED_CORE -- requirements
Module: arf_sched_core

Interface
REQ-001 The block SHALL have parameter W, default 16, signed sample/coefficient width.
REQ-002 The block SHALL have parameter FRAC, default 8, fractional bits of the Q format (1.0 = 2^FRAC).
REQ-003 The block SHALL have parameter APPROX_BITS, default 4, product LSBs cleared in approximate mode.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-005 The block SHALL have x_in  in  8*W  packed signed samples x0..x7 (x0 at LSBs).
REQ-006 The block SHALL have in_valid  in  1, in_ready  out  1  for the input handshake.
REQ-007 The block SHALL have approx_en  in  1 and sat_en  in  1  as per-sample mode bits, sampled on input handshake.
REQ-008 The block SHALL have coef_we  in  1, coef_addr  in  4, coef_wdata  in  W  as the coefficient write port.
REQ-009 The block SHALL have clear_state  in  1  to zero the feedback registers.
REQ-010 The block SHALL have y0, y1  out  W each  signed results; out_valid  out  1; out_ready  in  1.
REQ-011 The block SHALL have busy  out  1, high whenever state is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, MUL1, ADD, MUL2, OUT; in_ready = (state==IDLE).
REQ-013 Input handshake (in_valid && in_ready) SHALL register x_in and mode bits and go IDLE->MUL1; MUL1->ADD->MUL2->OUT unconditionally, one cycle each.
REQ-014 out_valid SHALL be high exactly in OUT; first out_valid cycle is 4 cycles after the handshake cycle.
REQ-015 In OUT, y0/y1/out_valid SHALL hold stable until out_ready; on out_valid && out_ready go OUT->IDLE and load fb0<=y0, fb1<=y1.
REQ-016 MUL1: p_i = sat_W((x_i*c_i) >>> FRAC), i=0..7, arithmetic shift, always saturating.
REQ-017 ADD: b0 = p0+p1+p2+p3+fb0; b1 = p4+p5+p6+p7+fb1; intermediate sums at W+3 bits, final result saturated to W if sat_en else wrapped to W.
REQ-018 MUL2: y0 = add(sat_W((b0*c8)>>>FRAC), sat_W((b1*c9)>>>FRAC)); y1 = add(sat_W((b0*c10)>>>FRAC), sat_W((b1*c11)>>>FRAC)); add saturates or wraps per sat_en.
REQ-019 If approx_en, the low APPROX_BITS of every MUL1 and MUL2 product SHALL be cleared after shift/saturation.
REQ-020 Coefficient file c0..c11 SHALL be written on coef_we only when state==IDLE; writes while busy or with coef_addr>=12 SHALL be ignored.
REQ-021 A coefficient write and an input handshake in the same cycle SHALL both take effect, and the new coefficient SHALL be used by that sample.
REQ-022 clear_state SHALL zero fb0/fb1 only when state==IDLE; if coincident with an input handshake, that sample SHALL use fb=0.
REQ-023 in_valid outside IDLE SHALL be ignored; x_in changes outside the handshake cycle SHALL not affect results.

Reset
REQ-024 On rst, regardless of state, next cycle: state IDLE, in_ready=1, out_valid=0, busy=0, y0=y1=0, fb0=fb1=0, c0..c11=0.
REQ-025 rst SHALL dominate coef_we, clear_state and handshakes in the same cycle.

Verification (W=16, FRAC=8, APPROX_BITS=4)
REQ-026 All c=256, x_i=256, fb=0, out_ready=1 -> y0=y1=2048 four cycles after handshake; repeat same sample -> y0=y1=6144; then clear_state, repeat -> 2048.
REQ-027 x_i=32767, c0..c7=32767, sat_en=1 -> p_i=32767, b0=b1=32767; sat_en=0 with c0..c7=256, x_i=16384 -> b0 wraps to 0.
REQ-028 out_ready low 5 cycles in OUT -> y0/y1/out_valid stable, in_ready=0, fb unchanged; out_ready high -> IDLE next cycle, fb updated.
REQ-029 x0=291, c0=256, other x=0, c8=256, approx_en=1 -> p0=288 (0x120), y0=288; approx_en=0 -> y0=291.
REQ-030 rst asserted in ADD -> next cycle out_valid=0, in_ready=1, all coefficients 0; coef_we while busy -> coefficient unchanged.
